// File: rtl/turbo_enc_pkg.sv
// Shared types and constants for the parametrised turbo encoder: FSM states,
// rate encodings, termination length and the row/column interleaver map.
package turbo_enc_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ENC   = 2'd1,
    TAIL1 = 2'd2,
    TAIL2 = 2'd3
  } state_e;

  localparam logic RATE_1_3   = 1'b0;
  localparam logic RATE_1_2   = 1'b1;
  localparam int   TAIL_STEPS = 2;
  localparam int   MEM        = 2;

  // Written row-wise, read column-wise: step j fetches buffer index pi(j).
  function automatic int pi_index(input int j, input int rows, input int cols);
    return (j % rows) * cols + (j / rows);
  endfunction

endpackage

// File: rtl/turbo_enc_param_rsc_unit.sv
// Recursive systematic convolutional encoder, octal (7,5), memory 2.
// With tail=1 the input is forced to s1^s2 so the recursion feeds back zero.
module rsc_unit (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic step_en,
  input  logic tail,
  input  logic u,
  output logic p,
  output logic u_eff
);

  logic s1_q, s2_q;
  logic a;

  assign u_eff = tail ? (s1_q ^ s2_q) : u;
  assign a     = u_eff ^ s1_q ^ s2_q;
  assign p     = a ^ s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else if (init) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else if (step_en) begin
      s1_q <= a;
      s2_q <= s1_q;
    end
  end

endmodule

// File: rtl/turbo_enc_param.sv
// Parametrised block turbo encoder (two RSC 7/5 encoders, row/column interleaver,
// rate 1/3 or 1/2 puncturing, trellis termination). TURBO_ENC_PINGPONG_EN adds a second frame bank.
module turbo_enc_param
  import turbo_enc_pkg::*;
#(
  parameter int K    = 16,
  parameter int ROWS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rate_sel,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic busy
);

  localparam int COLS = K / ROWS;
  localparam int SW   = $clog2(K);

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [1:0]    sub_q, sub_d;
  logic [SW-1:0] ld_cnt_q, ld_cnt_d;
  logic          ld_bank_q, ld_bank_d;
  logic          enc_bank_q, enc_bank_d;
  logic          pend_q, pend_d;
  logic [K-1:0]  frame_q [2];
  logic          rate_q  [2];

  logic          in_fire, out_fire, load_done, frame_end, enc_free, start;
  logic [K-1:0]  cur_frame;
  logic          cur_rate;
  logic [SW-1:0] pi_idx;
  logic          u1, u2, p1, p2, ue1, ue2;
  logic          step_en1, step_en2, tail1, tail2, rsc_init;
  logic          step_last;

`ifdef TURBO_ENC_PINGPONG_EN
  localparam logic PP = 1'b1;
  assign in_ready = ~pend_q;
`else
  localparam logic PP = 1'b0;
  assign in_ready = (state_q == LOAD);
`endif

  assign cur_frame = frame_q[enc_bank_q];
  assign cur_rate  = rate_q[enc_bank_q];
  assign pi_idx    = SW'(pi_index(32'(step_q), ROWS, COLS));
  assign u1        = cur_frame[step_q];
  assign u2        = cur_frame[pi_idx];

  assign out_valid = (state_q != LOAD);
  assign out_last  = (state_q == TAIL2) && (step_q == SW'(TAIL_STEPS - 1)) && (sub_q == 2'd1);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign load_done = in_fire && (ld_cnt_q == SW'(K - 1));
  assign frame_end = out_fire && out_last;
  assign enc_free  = (state_q == LOAD) || frame_end;
  assign start     = enc_free && (pend_q || load_done);
  assign busy      = (state_q != LOAD) || (ld_cnt_q != '0) || pend_q;

  rsc_unit u_rsc1 (
    .clk     (clk),
    .rst     (rst),
    .init    (rsc_init),
    .step_en (step_en1),
    .tail    (tail1),
    .u       (u1),
    .p       (p1),
    .u_eff   (ue1)
  );

  rsc_unit u_rsc2 (
    .clk     (clk),
    .rst     (rst),
    .init    (rsc_init),
    .step_en (step_en2),
    .tail    (tail2),
    .u       (u2),
    .p       (p2),
    .u_eff   (ue2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      step_q     <= '0;
      sub_q      <= '0;
      ld_cnt_q   <= '0;
      ld_bank_q  <= 1'b0;
      enc_bank_q <= 1'b0;
      pend_q     <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        frame_q[b] <= '0;
        rate_q[b]  <= RATE_1_3;
      end
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      sub_q      <= sub_d;
      ld_cnt_q   <= ld_cnt_d;
      ld_bank_q  <= ld_bank_d;
      enc_bank_q <= enc_bank_d;
      pend_q     <= pend_d;
      if (in_fire) begin
        frame_q[ld_bank_q][ld_cnt_q] <= in_bit;
        if (ld_cnt_q == '0) rate_q[ld_bank_q] <= rate_sel;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    sub_d      = sub_q;
    ld_cnt_d   = ld_cnt_q;
    ld_bank_d  = ld_bank_q;
    enc_bank_d = enc_bank_q;
    pend_d     = pend_q;
    out_bit    = 1'b0;
    step_en1   = 1'b0;
    step_en2   = 1'b0;
    tail1      = 1'b0;
    tail2      = 1'b0;
    rsc_init   = 1'b0;
    step_last  = 1'b0;

    case (state_q)
      ENC: begin
        case (sub_q)
          2'd0:    out_bit = u1;
          2'd1:    out_bit = (cur_rate == RATE_1_2 && step_q[0]) ? p2 : p1;
          default: out_bit = p2;
        endcase
        step_last = (cur_rate == RATE_1_3) ? (sub_q == 2'd2) : (sub_q == 2'd1);
        if (out_fire) begin
          if (step_last) begin
            step_en1 = 1'b1;
            step_en2 = 1'b1;
            sub_d    = '0;
            if (step_q == SW'(K - 1)) begin
              state_d = TAIL1;
              step_d  = '0;
            end else begin
              step_d = step_q + SW'(1);
            end
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      TAIL1: begin
        tail1   = 1'b1;
        out_bit = (sub_q == 2'd0) ? ue1 : p1;
        if (out_fire) begin
          if (sub_q == 2'd1) begin
            step_en1 = 1'b1;
            sub_d    = '0;
            if (step_q == SW'(TAIL_STEPS - 1)) begin
              state_d = TAIL2;
              step_d  = '0;
            end else begin
              step_d = step_q + SW'(1);
            end
          end else begin
            sub_d = 2'd1;
          end
        end
      end
      TAIL2: begin
        tail2   = 1'b1;
        out_bit = (sub_q == 2'd0) ? ue2 : p2;
        if (out_fire) begin
          if (sub_q == 2'd1) begin
            step_en2 = 1'b1;
            sub_d    = '0;
            if (out_last) begin
              state_d  = LOAD;
              step_d   = '0;
              rsc_init = 1'b1;
            end else begin
              step_d = step_q + SW'(1);
            end
          end else begin
            sub_d = 2'd1;
          end
        end
      end
      default: ;
    endcase

    if (in_fire) begin
      if (ld_cnt_q == SW'(K - 1)) begin
        ld_cnt_d  = '0;
        ld_bank_d = ld_bank_q ^ PP;
      end else begin
        ld_cnt_d = ld_cnt_q + SW'(1);
      end
    end

    // A full bank waits in pend_q until the encoder frees up at out_last.
    if (start) begin
      state_d    = ENC;
      enc_bank_d = pend_q ? (enc_bank_q ^ PP) : ld_bank_q;
      pend_d     = 1'b0;
    end else if (load_done) begin
      pend_d = 1'b1;
    end
  end

endmodule
